seq_forward_layer: RTL and testbench

- Time-multiplexed, parametrised successor to the combinational forward neuron array.
- Computes a = act(A·x + b) for M neurons with N inputs each, using P parallel MAC lanes over ceil(M/P) passes.
- Fixed-point signed arithmetic with saturation; selectable activation.
- Valid/ready handshakes on both input and output so layers chain into a pipelined network.

---
 rtl/nn_pkg.sv | 65 ++++++
 rtl/neuron_mac_lane.sv | 53 +++++
 rtl/seq_forward_layer.sv | 176 +++++++++++++++++
 tb/tb_seq_forward_layer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the sequential forward layer.
// Contents:
//   DW, FRAC     : data word width and fractional bits (Q(DW-FRAC).FRAC)
//   data_type    : signed data word
//   act_sel_t    : activation selector encoding
//   state_t      : layer controller states
//   saturate()   : clamps a wide signed value to data_type, reports clipping
//   activate()   : applies the selected activation to a saturated word
// Optional feature macro: LEAKY_RELU_EN (act_sel=2 selects leaky ReLU with
// slope 1/8; without it act_sel=2 behaves as ReLU and no shifter exists).
package nn_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int WIDE = 64;

  typedef logic signed [DW-1:0] data_type;

  typedef enum logic [1:0] {
    ACT_RELU     = 2'd0,
    ACT_IDENTITY = 2'd1,
    ACT_LEAKY    = 2'd2,
    ACT_RELU_ALT = 2'd3
  } act_sel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  typedef struct packed {
    data_type value;
    logic     sat;
  } sat_result_t;

  localparam data_type DATA_MAX = data_type'({1'b0, {(DW-1){1'b1}}});
  localparam data_type DATA_MIN = data_type'({1'b1, {(DW-1){1'b0}}});

  function automatic sat_result_t saturate(input logic signed [WIDE-1:0] v);
    sat_result_t r;
    r.sat   = 1'b0;
    r.value = v[DW-1:0];
    if (v > WIDE'(DATA_MAX)) begin
      r.sat   = 1'b1;
      r.value = DATA_MAX;
    end else if (v < WIDE'(DATA_MIN)) begin
      r.sat   = 1'b1;
      r.value = DATA_MIN;
    end
    return r;
  endfunction

  function automatic data_type activate(input data_type z, input act_sel_t sel);
    case (sel)
      ACT_IDENTITY: return z;
`ifdef LEAKY_RELU_EN
      ACT_LEAKY:    return z[DW-1] ? (z >>> 3) : z;
`endif
      default:      return z[DW-1] ? '0 : z;
    endcase
  endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// One multiply-accumulate lane of the sequential forward layer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (start of a pass)
//   enable     : accumulate weight*x this cycle
//   weight, x  : current product operands
//   bias       : bias of the neuron this lane is serving
//   z          : saturated (acc + bias<<FRAC) >>> FRAC, valid combinationally
//   sat        : z was clipped
module neuron_mac_lane
  import nn_pkg::*;
#(
  parameter int N = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  input  logic     enable,
  input  data_type weight,
  input  data_type x,
  input  data_type bias,
  output data_type z,
  output logic     sat
);

  // Wide enough that N full-scale products can never overflow.
  localparam int AW = 2*DW + $clog2(N) + 1;

  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] product;
  logic signed [AW:0]     biased;
  logic signed [AW:0]     shifted;
  sat_result_t            result;

  assign product = (2*DW)'(weight) * (2*DW)'(x);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + AW'(product);
    end
  end

  // Bias is aligned to the product's 2*FRAC fractional bits before the
  // final arithmetic shift back down to FRAC.
  assign biased  = (AW+1)'(acc) + ((AW+1)'(bias) <<< FRAC);
  assign shifted = biased >>> FRAC;
  assign result  = saturate(WIDE'(shifted));
  assign z       = result.value;
  assign sat     = result.sat;

endmodule

// File: rtl/seq_forward_layer.sv
// Time-multiplexed fully connected layer: a = act(A*x + b) for M neurons with
// N inputs each, using P MAC lanes over ceil(M/P) passes of N+1 cycles.
// Data width and fractional bits come from nn_pkg (DW, FRAC).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : job handshake (A, x, b, act_sel latched on accept)
//   A                    : weights, element [n][k] at bits (n*N+k)*DW +: DW
//   x                    : inputs, element [k] at bits k*DW +: DW
//   b                    : biases, element [n] at bits n*DW +: DW
//   act_sel              : 0/3 ReLU, 1 identity, 2 leaky (LEAKY_RELU_EN) or ReLU
//   out_valid / out_ready: result handshake
//   a                    : activations, element [n] at bits n*DW +: DW
//   sat_flag             : some neuron of the current result saturated
//   busy                 : controller not idle
// Optional feature macro: LEAKY_RELU_EN (handled inside nn_pkg::activate).
module seq_forward_layer
  import nn_pkg::*;
#(
  parameter int M = 5,
  parameter int N = 3,
  parameter int P = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M*N*DW-1:0] A,
  input  logic [N*DW-1:0]   x,
  input  logic [M*DW-1:0]   b,
  input  logic [1:0]        act_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M*DW-1:0]   a,
  output logic              sat_flag,
  output logic              busy
);

  localparam int PASSES = (M + P - 1) / P;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int KW     = (N > 1) ? $clog2(N) : 1;
  localparam int MW     = (M > 1) ? $clog2(M) : 1;

  state_t   state, next_state;
  logic [PW-1:0] pass;
  logic [KW-1:0] k;
  logic     accept, lane_clear, lane_enable, last_k, last_pass;

  data_type a_lat [M][N];
  data_type x_lat [N];
  data_type b_lat [M];
  data_type a_reg [M];
  act_sel_t act_lat;

  data_type      lane_w [P];
  data_type      lane_b [P];
  data_type      lane_z [P];
  logic [MW-1:0] lane_n [P];
  logic [P-1:0]  lane_live;
  logic [P-1:0]  lane_sat;

  assign last_k    = (k == KW'(N - 1));
  assign last_pass = (pass == PW'(PASSES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Accumulators are cleared on the accepting edge and on every WB edge so
  // each pass starts from zero.
  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    accept      = 1'b0;
    lane_clear  = 1'b0;
    lane_enable = 1'b0;
    out_valid   = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          accept     = 1'b1;
          lane_clear = 1'b1;
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        lane_enable = 1'b1;
        if (last_k) next_state = S_WB;
      end
      S_WB: begin
        lane_clear = 1'b1;
        next_state = last_pass ? S_DONE : S_MAC;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Lane j serves neuron pass*P + j; lanes past M in the final pass are fed
  // zeros and never write back.
  for (genvar j = 0; j < P; j++) begin : g_lane
    logic [31:0] n_full;
    assign n_full       = 32'(pass) * 32'(P) + 32'(j);
    assign lane_live[j] = (n_full < 32'(M));
    assign lane_n[j]    = lane_live[j] ? MW'(n_full) : '0;
    assign lane_w[j]    = lane_live[j] ? a_lat[lane_n[j]][k] : '0;
    assign lane_b[j]    = lane_live[j] ? b_lat[lane_n[j]] : '0;

    neuron_mac_lane #(.N(N)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (lane_clear),
      .enable (lane_enable),
      .weight (lane_w[j]),
      .x      (x_lat[k]),
      .bias   (lane_b[j]),
      .z      (lane_z[j]),
      .sat    (lane_sat[j])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass     <= '0;
      k        <= '0;
      sat_flag <= 1'b0;
      act_lat  <= ACT_RELU;
      for (int n = 0; n < M; n++) begin
        a_reg[n] <= '0;
        b_lat[n] <= '0;
        for (int c = 0; c < N; c++) a_lat[n][c] <= '0;
      end
      for (int c = 0; c < N; c++) x_lat[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pass     <= '0;
            k        <= '0;
            sat_flag <= 1'b0;
            act_lat  <= act_sel_t'(act_sel);
            for (int n = 0; n < M; n++) begin
              b_lat[n] <= b[n*DW +: DW];
              for (int c = 0; c < N; c++) a_lat[n][c] <= A[(n*N+c)*DW +: DW];
            end
            for (int c = 0; c < N; c++) x_lat[c] <= x[c*DW +: DW];
          end
        end
        S_MAC: begin
          k <= last_k ? '0 : k + 1'b1;
        end
        S_WB: begin
          for (int j = 0; j < P; j++) begin
            if (lane_live[j]) begin
              a_reg[lane_n[j]] <= activate(lane_z[j], act_lat);
              if (lane_sat[j]) sat_flag <= 1'b1;
            end
          end
          k <= '0;
          if (!last_pass) pass <= pass + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar n = 0; n < M; n++) begin : g_out
    assign a[n*DW +: DW] = a_reg[n];
  end

endmodule

// File: tb/tb_seq_forward_layer.sv
// Self-checking bench for seq_forward_layer (M=5, N=3, P=2, DW=16, FRAC=8).
module tb_seq_forward_layer;

  localparam int M = 5;
  localparam int N = 3;
  localparam int P = 2;
  localparam int DW = 16;
  localparam int FRAC = 8;
  localparam int EXP_LAT = ((M + P - 1) / P) * (N + 1);
  localparam int TIMEOUT = 60;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [M*N*DW-1:0] A = '0;
  logic [N*DW-1:0]   x = '0;
  logic [M*DW-1:0]   b = '0;
  logic [1:0]        act_sel = 2'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [M*DW-1:0]   a;
  logic              sat_flag;
  logic              busy;

  int total = 0;
  int bad = 0;

  // Current job as seen by the reference model.
  logic signed [DW-1:0] ja [M][N];
  logic signed [DW-1:0] jx [N];
  logic signed [DW-1:0] jb [M];
  logic [1:0]           jsel;
  logic [DW-1:0]        exp_a [M];
  logic                 exp_sat;

  seq_forward_layer #(.M(M), .N(N), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .x         (x),
    .b         (b),
    .act_sel   (act_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] a_of(input int n);
    return a[n*DW +: DW];
  endfunction

  // Reference: exact integer dot product, bias scaled into the product
  // domain, floor division by 2^FRAC, clamp, then activation.
  task automatic compute_model();
    exp_sat = 1'b0;
    for (int n = 0; n < M; n++) begin
      longint sum = 0;
      longint z;
      for (int c = 0; c < N; c++) sum += longint'(ja[n][c]) * longint'(jx[c]);
      z = (sum + longint'(jb[n]) * (longint'(1) << FRAC)) >>> FRAC;
      if (z > 32767) begin
        z = 32767;
        exp_sat = 1'b1;
      end else if (z < -32768) begin
        z = -32768;
        exp_sat = 1'b1;
      end
      if (jsel == 2'd1) begin
      end
`ifdef LEAKY_RELU_EN
      else if (jsel == 2'd2) begin
        if (z < 0) z = z >>> 3;
      end
`endif
      else begin
        if (z < 0) z = 0;
      end
      exp_a[n] = z[DW-1:0];
    end
  endtask

  task automatic set_plan_job();
    for (int n = 0; n < M; n++) begin
      jb[n] = 16'sh0000;
      for (int c = 0; c < N; c++) ja[n][c] = 16'sh0100;
    end
    jx[0] = 16'sh0100;
    jx[1] = 16'sh0200;
    jx[2] = 16'sh0300;
    jsel = 2'd0;
  endtask

  task automatic drive_job();
    for (int n = 0; n < M; n++) begin
      b[n*DW +: DW] = jb[n];
      for (int c = 0; c < N; c++) A[(n*N+c)*DW +: DW] = ja[n][c];
    end
    for (int c = 0; c < N; c++) x[c*DW +: DW] = jx[c];
    act_sel = jsel;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < M*N; i++) A[i*DW +: DW] = 16'($urandom);
    for (int i = 0; i < N; i++) x[i*DW +: DW] = 16'($urandom);
    for (int i = 0; i < M; i++) b[i*DW +: DW] = 16'($urandom);
    act_sel = 2'($urandom_range(0, 3));
  endtask

  // Presents the job, scrambles inputs after the accepting edge and counts
  // edges until out_valid; lat reaches TIMEOUT if it never arrives.
  task automatic run_job(output int lat);
    compute_model();
    @(negedge clk);
    drive_job();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got valid=%b busy=%b sat=%b expected 0 0 0", out_valid, busy, sat_flag);
    end
    total++;
    if (a !== '0) begin
      bad++;
      $display("[TB] FAIL reset_a: got %h expected 0", a);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    set_plan_job();
    run_job(lat);
    total++;
    if (lat !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT);
    end
    for (int n = 0; n < M; n++) begin
      total++;
      if (a_of(n) !== exp_a[n] || a_of(n) !== 16'h0600) begin
        bad++;
        $display("[TB] FAIL basic_a%0d: got %h expected %h", n, a_of(n), exp_a[n]);
      end
    end
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_sat: got %b expected 0", sat_flag);
    end
    release_output();
  endtask

  task automatic test_activation();
    int lat;
    for (int s = 0; s < 4; s++) begin
      set_plan_job();
      for (int c = 0; c < N; c++) ja[0][c] = 16'shFF00;
      jsel = 2'(s);
      run_job(lat);
      total++;
      if (lat !== EXP_LAT) begin
        bad++;
        $display("[TB] FAIL act%0d_latency: got %0d expected %0d", s, lat, EXP_LAT);
      end
      for (int n = 0; n < M; n++) begin
        total++;
        if (a_of(n) !== exp_a[n]) begin
          bad++;
          $display("[TB] FAIL act%0d_a%0d: got %h expected %h", s, n, a_of(n), exp_a[n]);
        end
      end
      release_output();
    end
  endtask

  task automatic test_saturation();
    int lat;
    for (int n = 0; n < M; n++) begin
      jb[n] = 16'sh7FFF;
      for (int c = 0; c < N; c++) ja[n][c] = 16'sh7F00;
    end
    for (int c = 0; c < N; c++) jx[c] = 16'sh7F00;
    jsel = 2'd0;
    run_job(lat);
    for (int n = 0; n < M; n++) begin
      total++;
      if (a_of(n) !== exp_a[n] || a_of(n) !== 16'h7FFF) begin
        bad++;
        $display("[TB] FAIL sat_a%0d: got %h expected %h", n, a_of(n), exp_a[n]);
      end
    end
    total++;
    if (sat_flag !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_flag_set: got %b expected 1", sat_flag);
    end
    release_output();
    set_plan_job();
    run_job(lat);
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sat_flag_clear: got %b expected 0", sat_flag);
    end
    release_output();
  endtask

  task automatic test_hold_done();
    int lat;
    logic [M*DW-1:0] held;
    set_plan_job();
    ja[2][1] = 16'sh0280;
    jb[4] = 16'shFE00;
    jsel = 2'd1;
    run_job(lat);
    for (int n = 0; n < M; n++) held[n*DW +: DW] = exp_a[n];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      scramble_inputs();
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sat_flag !== exp_sat) begin
        bad++;
        $display("[TB] FAIL hold_ctrl%0d: got valid=%b ready=%b sat=%b expected 1 0 %b", i, out_valid, in_ready, sat_flag, exp_sat);
      end
      total++;
      if (a !== held) begin
        bad++;
        $display("[TB] FAIL hold_a%0d: got %h expected %h", i, a, held);
      end
    end
    in_valid = 1'b0;
    release_output();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_release: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || a !== held) begin
      bad++;
      $display("[TB] FAIL hold_idle: got valid=%b busy=%b a=%h expected 0 0 %h", out_valid, busy, a, held);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_plan_job();
    @(negedge clk);
    drive_job();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_ctrl: got valid=%b busy=%b ready=%b expected 0 0 0", out_valid, busy, in_ready);
    end
    total++;
    if (a !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_a: got %h expected 0", a);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready);
    end
    run_job(lat);
    total++;
    if (lat !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, EXP_LAT);
    end
    for (int n = 0; n < M; n++) begin
      total++;
      if (a_of(n) !== exp_a[n]) begin
        bad++;
        $display("[TB] FAIL midreset_a%0d: got %h expected %h", n, a_of(n), exp_a[n]);
      end
    end
    release_output();
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 12; t++) begin
      bit big;
      big = (t % 3 == 2);
      for (int n = 0; n < M; n++) begin
        jb[n] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 2047)) - 1024);
        for (int c = 0; c < N; c++)
          ja[n][c] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
      end
      for (int c = 0; c < N; c++)
        jx[c] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
      jsel = 2'($urandom_range(0, 3));
      run_job(lat);
      total++;
      if (lat !== EXP_LAT) begin
        bad++;
        $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", t, lat, EXP_LAT);
      end
      for (int n = 0; n < M; n++) begin
        total++;
        if (a_of(n) !== exp_a[n]) begin
          bad++;
          $display("[TB] FAIL rand%0d_a%0d: got %h expected %h", t, n, a_of(n), exp_a[n]);
        end
      end
      total++;
      if (sat_flag !== exp_sat) begin
        bad++;
        $display("[TB] FAIL rand%0d_sat: got %b expected %b", t, sat_flag, exp_sat);
      end
      release_output();
    end
  endtask

  initial begin
    $display("[TB] starting seq_forward_layer bench");
    test_reset();
    test_basic();
    test_activation();
    test_saturation();
    test_hold_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
